// File: rtl/text_pkg.sv
// Shared definitions for the text RAM arbiter: default widths, clear fill code
// and the clear FSM state encoding.
package text_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 8;
    localparam logic [7:0] CLR_CHAR_DEF = 8'h20;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/text_wr_fifo.sv
// Host write queue for the text RAM arbiter: power-of-2 depth circular buffer
// with an occupancy count from which full and empty are derived.
module text_wr_fifo #(
    parameter  int WIDTH = 19,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign data    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/text_ram_arbiter.sv
// Single-port text RAM arbiter: display fetch > queued host write > screen clear.
// The screen-clear engine is built only when TEXT_CLEAR_EN is defined.
module text_ram_arbiter
    import text_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                FIFO_DEPTH = 4,
    parameter int                CELLS      = 2000,
    parameter logic [DATA_W-1:0] CLR_CHAR   = DATA_W'(CLR_CHAR_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lcden,
    input  logic [ADDR_W-1:0] i_cellnum,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_full,
    input  logic              i_clr_req,
    output logic              o_clr_busy,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_ram_rd,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                     fetch;
    logic                     wr_grant;
    logic                     clr_grant;
    logic [ADDR_W-1:0]        clr_addr;
    logic [ADDR_W-1:0]        last_addr;
    logic                     last_valid;
    logic                     push;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [CNT_W-1:0]         count;
    logic                     full;
    logic                     empty;

    assign fetch    = i_lcden && (!last_valid || (i_cellnum != last_addr));
    assign push     = i_wr_req && !full;
    assign wr_grant = !fetch && !empty;

    text_wr_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .pop       (wr_grant),
        .push_data ({i_wr_addr, i_wr_data}),
        .data      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Queue status comes straight from the registered occupancy count.
    assign o_wr_full = full;
    assign o_busy    = (count != '0);

    // Any cycle with the display off forgets the last fetch, so re-enabling
    // always refetches even when the cell index is unchanged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_addr  <= '0;
            last_valid <= 1'b0;
        end else if (!i_lcden) begin
            last_valid <= 1'b0;
        end else if (fetch) begin
            last_addr  <= i_cellnum;
            last_valid <= 1'b1;
        end
    end

`ifdef TEXT_CLEAR_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CELLS - 1);

    clr_state_t clr_state;
    clr_state_t clr_next;

    assign clr_grant  = !fetch && empty && (clr_state == CLR_RUN);
    assign o_clr_busy = (clr_state == CLR_RUN);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            clr_state <= CLR_IDLE;
            clr_addr  <= '0;
        end else begin
            clr_state <= clr_next;
            if (clr_grant) clr_addr <= (clr_addr == CLR_LAST) ? '0 : clr_addr + 1'b1;
        end
    end

    always_comb begin
        clr_next = clr_state;
        case (clr_state)
            CLR_IDLE: if (i_clr_req) clr_next = CLR_RUN;
            CLR_RUN:  if (clr_grant && (clr_addr == CLR_LAST)) clr_next = CLR_IDLE;
            default:  clr_next = CLR_IDLE;
        endcase
    end
`else
    logic unused_clr;

    assign unused_clr = ^{i_clr_req, CLR_CHAR, CELLS[0]};
    assign clr_grant  = 1'b0;
    assign clr_addr   = '0;
    assign o_clr_busy = 1'b0;
`endif

    // The granted access is registered so the RAM sees it one cycle later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ram_addr  <= '0;
            o_ram_we    <= 1'b0;
            o_ram_wdata <= '0;
            o_ram_rd    <= 1'b0;
        end else begin
            o_ram_addr  <= '0;
            o_ram_we    <= 1'b0;
            o_ram_wdata <= '0;
            o_ram_rd    <= 1'b0;
            if (fetch) begin
                o_ram_rd   <= 1'b1;
                o_ram_addr <= i_cellnum;
            end else if (wr_grant) begin
                o_ram_we    <= 1'b1;
                o_ram_addr  <= head[ADDR_W+DATA_W-1:DATA_W];
                o_ram_wdata <= head[DATA_W-1:0];
            end else if (clr_grant) begin
                o_ram_we    <= 1'b1;
                o_ram_addr  <= clr_addr;
                o_ram_wdata <= CLR_CHAR;
            end
        end
    end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed bench for text_ram_arbiter: vector table plus clear/reset sequences.
// Clear-engine sequences are compiled in when TEXT_CLEAR_EN is defined.
module tb_text_ram_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int CELLS  = 2000;
    localparam int NVEC   = 36;

    logic              clk = 1'b0;
    logic              rst;
    logic              lcden;
    logic [ADDR_W-1:0] cellnum;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic              wr_full;
    logic              clr_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_rd;
    logic              busy;

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        logic              lcden;
        logic [ADDR_W-1:0] cellnum;
        logic              wr_req;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_data;
        logic              rd;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              full;
        logic              busy;
    } vec_t;

    vec_t vecs [NVEC];

    text_ram_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_lcden     (lcden),
        .i_cellnum   (cellnum),
        .i_wr_req    (wr_req),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_wr_full   (wr_full),
        .i_clr_req   (clr_req),
        .o_clr_busy  (clr_busy),
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .o_ram_wdata (ram_wdata),
        .o_ram_rd    (ram_rd),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic l, input logic [ADDR_W-1:0] cn, input logic w,
                                 input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                                 input logic c);
        lcden   = l;
        cellnum = cn;
        wr_req  = w;
        wr_addr = wa;
        wr_data = wd;
        clr_req = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Address is only meaningful when an access is expected.
    task automatic checkIdle(input string name);
        checkOutput(name, {ram_rd, ram_we, ram_wdata, clr_busy, busy}, 64'd0);
    endtask

    initial begin
        vecs[0]  = '{1, 5, 0, 0, 0,         1, 0, 5, 0, 0, 0};
        for (int i = 1; i <= 8; i++)
            vecs[i] = '{1, 5, 0, 0, 0,      0, 0, 0, 0, 0, 0};
        vecs[9]  = '{1, 6, 0, 0, 0,         1, 0, 6, 0, 0, 0};
        vecs[10] = '{0, 6, 0, 0, 0,         0, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 1, 7, 'h41,      0, 0, 0, 0, 0, 1};
        vecs[12] = '{0, 0, 0, 0, 0,         0, 1, 7, 'h41, 0, 0};
        vecs[13] = '{1, 1, 1, 'h10, 'h01,   1, 0, 1, 0, 0, 1};
        vecs[14] = '{1, 2, 1, 'h11, 'h02,   1, 0, 2, 0, 0, 1};
        vecs[15] = '{1, 1, 1, 'h12, 'h03,   1, 0, 1, 0, 0, 1};
        vecs[16] = '{1, 2, 1, 'h13, 'h04,   1, 0, 2, 0, 1, 1};
        vecs[17] = '{1, 1, 1, 'h14, 'h05,   1, 0, 1, 0, 1, 1};
        vecs[18] = '{0, 0, 0, 0, 0,         0, 1, 'h10, 'h01, 0, 1};
        vecs[19] = '{0, 0, 0, 0, 0,         0, 1, 'h11, 'h02, 0, 1};
        vecs[20] = '{0, 0, 0, 0, 0,         0, 1, 'h12, 'h03, 0, 1};
        vecs[21] = '{0, 0, 0, 0, 0,         0, 1, 'h13, 'h04, 0, 0};
        vecs[22] = '{0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0};
        vecs[23] = '{1, 3, 1, 'h20, 'h11,   1, 0, 3, 0, 0, 1};
        vecs[24] = '{1, 4, 1, 'h21, 'h12,   1, 0, 4, 0, 0, 1};
        vecs[25] = '{1, 3, 1, 'h22, 'h13,   1, 0, 3, 0, 0, 1};
        vecs[26] = '{1, 4, 1, 'h23, 'h14,   1, 0, 4, 0, 1, 1};
        vecs[27] = '{0, 0, 1, 'h24, 'h15,   0, 1, 'h20, 'h11, 0, 1};
        vecs[28] = '{0, 0, 1, 'h25, 'h16,   0, 1, 'h21, 'h12, 0, 1};
        vecs[29] = '{0, 0, 0, 0, 0,         0, 1, 'h22, 'h13, 0, 1};
        vecs[30] = '{0, 0, 0, 0, 0,         0, 1, 'h23, 'h14, 0, 1};
        vecs[31] = '{0, 0, 0, 0, 0,         0, 1, 'h25, 'h16, 0, 0};
        vecs[32] = '{0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0};
        vecs[33] = '{1, 9, 1, 'h30, 'h21,   1, 0, 9, 0, 0, 1};
        vecs[34] = '{1, 9, 0, 0, 0,         0, 1, 'h30, 'h21, 0, 0};
        vecs[35] = '{0, 9, 0, 0, 0,         0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        lcden = 0; cellnum = '0; wr_req = 0; wr_addr = '0; wr_data = '0; clr_req = 0;
        #2;
        checkOutput("reset_state", {ram_rd, ram_we, ram_addr, ram_wdata, wr_full, clr_busy, busy}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].lcden, vecs[i].cellnum, vecs[i].wr_req,
                          vecs[i].wr_addr, vecs[i].wr_data, 1'b0);
            checkOutput($sformatf("vec%0d", i),
                        {ram_rd, ram_we, (ram_rd | ram_we) ? ram_addr : 11'd0,
                         ram_wdata, wr_full, busy, clr_busy},
                        {vecs[i].rd, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                         vecs[i].full, vecs[i].busy, 1'b0});
        end

`ifdef TEXT_CLEAR_EN
        // Full clear with an ignored second request, then clear with a host write injected.
        for (int pass = 0; pass < 2; pass++) begin
            int  next_clr     = 0;
            bit  host_pending = 0;
            bit  host_sent    = 0;
            int  total        = CELLS + pass;
            applyStimulus(0, 0, 0, 0, 0, 1);
            checkOutput("clr_start", {ram_we, clr_busy}, {1'b0, 1'b1});
            for (int k = 0; k < total; k++) begin
                logic hv;
                logic cv;
                hv = (pass == 1) && (next_clr == 10) && !host_sent;
                cv = (pass == 0) && (next_clr == 1000);
                applyStimulus(0, 0, hv, 3, 'h55, cv);
                if (host_pending) begin
                    checkOutput("clr_host", {ram_we, ram_addr, ram_wdata, clr_busy},
                                {1'b1, 11'd3, 8'h55, 1'b1});
                    host_pending = 0;
                end else begin
                    checkOutput($sformatf("clr_wr%0d", next_clr),
                                {ram_we, ram_addr, ram_wdata, clr_busy},
                                {1'b1, 11'(next_clr), 8'h20, 1'(next_clr != CELLS - 1)});
                    next_clr++;
                end
                if (hv) begin
                    host_pending = 1;
                    host_sent    = 1;
                end
            end
            for (int k = 0; k < 4; k++) begin
                applyStimulus(0, 0, 0, 0, 0, 0);
                checkIdle("clr_after");
            end
        end

        // Reset mid-clear with two host writes waiting behind display fetches.
        applyStimulus(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 0, 0);
`endif
        applyStimulus(1, 1, 1, 'h40, 'h61, 0);
        applyStimulus(1, 2, 1, 'h41, 'h62, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 2, 0, 0, 0, 0);
        checkOutput("pre_rst_queue", {busy, ram_rd}, {1'b1, 1'b1});
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_immediate", {ram_rd, ram_we, ram_addr, ram_wdata, wr_full, clr_busy, busy}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1, 2, 0, 0, 0, 0);
        checkOutput("rst_refetch", {ram_rd, ram_we, ram_addr, busy}, {1'b1, 1'b0, 11'd2, 1'b0});
        for (int k = 0; k < 12; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkIdle($sformatf("rst_after%0d", k));
        end

`ifndef TEXT_CLEAR_EN
        applyStimulus(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            checkIdle($sformatf("clr_ignored%0d", k));
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/text_ram_arbiter.md
TEXT_RAM_ARBITER -- requirements
Module: text_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, text RAM cell address width.
REQ-002 SHALL have parameter DATA_W, default 8, character code width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, host write queue entries (power of 2).
REQ-004 SHALL have parameter CELLS, default 2000, number of screen cells cleared.
REQ-005 SHALL have parameter CLR_CHAR, default 8'h20, clear fill code.
REQ-006 SHALL have ports: i_clk in 1 system clock; i_rst in 1 reset; one clock, reset asynchronous and active-high.
REQ-007 SHALL have ports: i_lcden in 1 display active; i_cellnum in ADDR_W display cell index.
REQ-008 SHALL have ports: i_wr_req in 1 host write; i_wr_addr in ADDR_W; i_wr_data in DATA_W; o_wr_full out 1 queue full.
REQ-009 SHALL have ports: i_clr_req in 1 start clear pulse; o_clr_busy out 1 clear in progress.
REQ-010 SHALL have ports: o_ram_addr out ADDR_W; o_ram_we out 1; o_ram_wdata out DATA_W; o_ram_rd out 1 display fetch strobe; o_busy out 1 queue non-empty.

Function
REQ-011 SHALL grant exactly one RAM access per i_clk rising edge, or none; o_ram_rd and o_ram_we never both 1.
REQ-012 SHALL register all o_ram_* outputs: the access decided in cycle N appears in cycle N+1.
REQ-013 SHALL raise a display fetch when i_lcden=1 and (last-fetched address invalid or i_cellnum differs from it); the fetch has highest priority.
REQ-014 SHALL store i_cellnum as last-fetched address on each fetch; SHALL invalidate it in any cycle with i_lcden=0.
REQ-015 SHALL grant the queue head a write in any cycle without a display fetch and with the queue non-empty; the entry pops in the same cycle.
REQ-016 SHALL grant a clear write only when there is no display fetch and the queue is empty.
REQ-017 SHALL accept a host write iff i_wr_req=1 and o_wr_full=0; requests while full are dropped.
REQ-018 SHALL compute full from the current count; a push at full is refused even if a pop occurs the same cycle.
REQ-019 SHALL allow simultaneous push and pop below full, count unchanged.
REQ-020 SHALL drive o_wr_full=(count==FIFO_DEPTH) and o_busy=(count!=0), both registered.
REQ-021 SHALL implement clear FSM CLR_IDLE -> CLR_RUN on i_clr_req=1 in CLR_IDLE; CLR_RUN -> CLR_IDLE after writing address CELLS-1.
REQ-022 SHALL write CLR_CHAR to addresses 0..CELLS-1 in ascending order while in CLR_RUN, advancing only on a granted clear slot.
REQ-023 SHALL ignore i_clr_req while in CLR_RUN; host writes stay accepted during clear and preempt it.
REQ-024 SHALL hold o_clr_busy=1 exactly while in CLR_RUN; it falls the cycle after the last clear write is issued.
REQ-025 SHALL drive o_ram_wdata=0 and o_ram_we=0 in cycles with no granted write.

Reset
REQ-026 SHALL on i_rst=1 immediately zero all outputs, empty the queue, invalidate the last-fetched address, and force CLR_IDLE.
REQ-027 SHALL abort a clear or queue drain when reset occurs mid-operation; no resumption after release.

Configuration
REQ-028 SHALL compile the clear FSM only when TEXT_CLEAR_EN is defined.
REQ-029 SHALL, without TEXT_CLEAR_EN, keep i_clr_req (ignored) and tie o_clr_busy to 0; all other behaviour is unchanged.

Structure
REQ-030 SHALL take ADDR_W/DATA_W defaults, CLR_CHAR and clear FSM state encodings from shared package text_pkg.
REQ-031 SHALL implement the write queue as sub-module text_wr_fifo (push, pop, data, count, full, empty).

Verification
REQ-032 SHALL test i_lcden=1, i_cellnum held at 5 for 9 cycles then 6 -> exactly two o_ram_rd pulses, addr 5 then 6, each one cycle late.
REQ-033 SHALL test 5 writes in consecutive cycles while fetches block all slots -> 4 accepted, o_wr_full=1, 5th dropped; i_lcden=0 -> 4 writes in order, o_busy falls.
REQ-034 SHALL test a write to addr 7/data 8'h41 during i_lcden=0, empty queue -> o_ram_we=1, addr 7, data 8'h41 two cycles after i_wr_req.
REQ-035 SHALL test i_clr_req with i_lcden=0 and TEXT_CLEAR_EN set -> 2000 writes of 8'h20 to addresses 0..1999, o_clr_busy high throughout; second i_clr_req mid-clear ignored.
REQ-036 SHALL test a host write to addr 3 injected mid-clear -> host write issued before the next clear address, clear resumes without gap or skip.
REQ-037 SHALL test i_rst asserted mid-clear with 2 entries queued -> outputs 0 immediately, no writes after release, o_clr_busy=0.
